fp_accum_ctrl: RTL and testbench

FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

---
 rtl/fp_accum_ctrl.sv | 125 ++++++++++++
 tb/tb_fp_accum_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: frames fp16 samples through an external multi-cycle adder and reports sum, count and sticky flags.
module fp_accum_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             add_st,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic             add_done,
  input  logic             add_ovf,
  input  logic             add_unf,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_ADD, OUTPUT, DISCARD} state_e;
  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             last_q, last_d, disc_q, disc_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic             take;
  assign in_ready  = !reset && (state_q == IDLE || state_q == WAIT_IN || state_q == DISCARD);
  assign add_st    = !reset && state_q == ISSUE;
  assign out_valid = !reset && state_q == OUTPUT;
  assign take      = in_valid & in_ready;
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign add_a     = acc_q;
  assign add_b     = b_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign out_err   = err_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    last_d  = last_q;
    disc_d  = disc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (take) begin
        acc_d   = in_data;
        cnt_d   = CNT_W'(1);
        state_d = in_last ? OUTPUT : WAIT_IN;
      end
      WAIT_IN: if (take) begin
        b_d     = in_data;
        last_d  = in_last;
        cnt_d   = cnt_inc;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = TW'(1);
        state_d = WAIT_ADD;
      end
      WAIT_ADD: begin
        if (add_done) begin
          acc_d = add_sum;
          unf_d = unf_q | add_unf;
        end else if (add_ovf) ovf_d = 1'b1;
        // the ISSUE cycle counts toward the timeout window
        if (add_done | add_ovf) state_d = last_q ? OUTPUT : WAIT_IN;
        else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          disc_d  = !last_q;
          state_d = OUTPUT;
        end else tmo_d = tmo_q + 1'b1;
      end
      OUTPUT: if (out_ready) begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        disc_d  = 1'b0;
        state_d = disc_q ? DISCARD : IDLE;
      end
      DISCARD: if (take && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      last_q  <= 1'b0;
      disc_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      disc_q  <= disc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb_fp_accum_ctrl: randomized frames against a frame-level reference model with a behavioural external adder.
module tb_fp_accum_ctrl;
  localparam int TIMEOUT = 64;
  localparam int CNT_W = 8;
  localparam int K_DONE = 0, K_OVF = 1, K_UNF = 2, K_NONE = 3;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic add_done = 0, add_ovf = 0, add_unf = 0;
  logic [15:0] in_data = 0, add_sum = 0;
  logic in_ready, add_st, out_valid, out_ovf, out_unf, out_err;
  logic [15:0] add_a, add_b, out_data;
  logic [CNT_W-1:0] out_count;
  int ncmp = 0, nerr = 0, cyc = 0, st_cnt = 0, st_cyc = 0, stab_bad = 0, pend = 0, cur_kind = 0;
  int kind_q[$], dly_q[$];
  logic [15:0] cap_a = 0, cap_b = 0, fixed_sum = 0;
  logic use_fixed = 0, rst_seen = 0;

  fp_accum_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .add_st(add_st), .add_a(add_a), .add_b(add_b), .add_done(add_done),
    .add_ovf(add_ovf), .add_unf(add_unf), .add_sum(add_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf),
    .out_unf(out_unf), .out_err(out_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External adder: responds after a per-operation delay; flags held until the next start.
  always @(negedge clk) begin
    if (reset) rst_seen = 1;
    if (add_st) begin
      st_cnt++;
      st_cyc = cyc;
      cap_a = add_a;
      cap_b = add_b;
      rst_seen = 0;
      add_done = 0; add_ovf = 0; add_unf = 0;
      cur_kind = kind_q.size() > 0 ? kind_q.pop_front() : K_DONE;
      pend = dly_q.size() > 0 ? dly_q.pop_front() : int'($urandom_range(1, 6));
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (!rst_seen && (add_a !== cap_a || add_b !== cap_b)) stab_bad++;
        add_sum  = use_fixed ? fixed_sum : cap_a + cap_b;
        add_done = cur_kind == K_DONE || cur_kind == K_UNF;
        add_ovf  = cur_kind == K_OVF;
        add_unf  = cur_kind == K_UNF;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) begin
      ncmp++; nerr++;
      $display("FAIL send_accept in_ready=0 after %0d cycles, required 1", n);
    end else @(negedge clk);
    in_valid = 0;
  endtask

  task automatic get_out(input logic [15:0] ed, input logic [CNT_W-1:0] ec,
                         input logic eo, input logic eu, input logic ee, input string nm);
    int n = 0;
    while (!out_valid && n < 1000) begin @(negedge clk); n++; end
    ncmp++;
    if (!out_valid) begin
      nerr++;
      $display("FAIL %s out_valid never rose, required 1", nm);
      return;
    end
    ncmp++;
    if (out_data !== ed) begin nerr++; $display("FAIL %s out_data=%h required %h", nm, out_data, ed); end
    ncmp++;
    if (out_count !== ec) begin nerr++; $display("FAIL %s out_count=%0d required %0d", nm, out_count, ec); end
    ncmp++;
    if ({out_ovf, out_unf, out_err} !== {eo, eu, ee}) begin
      nerr++;
      $display("FAIL %s flags ovf/unf/err=%b%b%b required %b%b%b", nm, out_ovf, out_unf, out_err, eo, eu, ee);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    ncmp++;
    if (out_valid !== 0 || out_count !== 0 || out_err !== 0) begin
      nerr++;
      $display("FAIL %s after handshake valid=%b count=%0d err=%b required 0/0/0", nm, out_valid, out_count, out_err);
    end
  endtask

  // Reference model: first sample seeds the sum, each further sample is one add whose outcome is chosen here.
  task automatic run_frame(input int n, input int pk_ovf, input int pk_unf, input int none_at, input int ovf_at, input string nm);
    logic [15:0] s[$];
    logic [15:0] acc;
    logic eo = 0, eu = 0, ee = 0;
    int cnt = 1, adds = 0, st0 = st_cnt, sb0 = stab_bad, k, r, n_wait;
    int maxc = (1 << CNT_W) - 1;
    for (int i = 0; i < n; i++) s.push_back(16'($urandom));
    acc = s[0];
    for (int i = 1; i < n; i++) begin
      if (ee) break;
      cnt = cnt < maxc ? cnt + 1 : cnt;
      adds++;
      r = int'($urandom_range(0, 99));
      k = i == none_at ? K_NONE : i == ovf_at ? K_OVF : r < pk_ovf ? K_OVF : r < pk_ovf + pk_unf ? K_UNF : K_DONE;
      kind_q.push_back(k);
      if (k == K_DONE || k == K_UNF) acc = acc + s[i];
      if (k == K_UNF) eu = 1;
      if (k == K_OVF) eo = 1;
      if (k == K_NONE) ee = 1;
    end
    if (ee) begin
      for (int i = 0; i <= none_at; i++) send(s[i], i == n - 1);
      n_wait = 0;
      while (!out_err && n_wait < 200) begin @(negedge clk); n_wait++; end
      ncmp++;
      if (cyc - st_cyc !== TIMEOUT) begin
        nerr++;
        $display("FAIL %s err_latency=%0d required %0d", nm, cyc - st_cyc, TIMEOUT);
      end
      get_out(acc, cnt[CNT_W-1:0], eo, eu, ee, nm);
      for (int i = none_at + 1; i < n; i++) send(s[i], i == n - 1);
    end else begin
      for (int i = 0; i < n; i++) send(s[i], i == n - 1);
      get_out(acc, cnt[CNT_W-1:0], eo, eu, ee, nm);
    end
    ncmp++;
    if (st_cnt - st0 !== adds) begin
      nerr++;
      $display("FAIL %s add_st_pulses=%0d required %0d", nm, st_cnt - st0, adds);
    end
    ncmp++;
    if (stab_bad !== sb0) begin
      nerr++;
      $display("FAIL %s operand_stability violations=%0d required 0", nm, stab_bad - sb0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    ncmp++;
    if ({in_ready, add_st, out_valid, out_ovf, out_unf, out_err} !== 6'b0 || add_a !== 0 || add_b !== 0 || out_data !== 0 || out_count !== 0) begin
      nerr++;
      $display("FAIL reset_state rdy=%b st=%b val=%b a=%h b=%h d=%h c=%0d required all 0", in_ready, add_st, out_valid, add_a, add_b, out_data, out_count);
    end
    reset = 0;
    @(negedge clk);
    ncmp++;
    if (in_ready !== 1) begin nerr++; $display("FAIL reset_release in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_single();
    int st0 = st_cnt;
    send(16'h3C00, 1);
    get_out(16'h3C00, 1, 0, 0, 0, "single");
    ncmp++;
    if (st_cnt !== st0) begin nerr++; $display("FAIL single add_st_pulses=%0d required 0", st_cnt - st0); end
  endtask

  task automatic test_pair();
    int st0 = st_cnt;
    use_fixed = 1; fixed_sum = 16'h4200; dly_q.push_back(5);
    send(16'h3C00, 0);
    send(16'h4000, 1);
    get_out(16'h4200, 2, 0, 0, 0, "pair");
    ncmp++;
    if (st_cnt - st0 !== 1 || cap_a !== 16'h3C00 || cap_b !== 16'h4000) begin
      nerr++;
      $display("FAIL pair pulses=%0d a=%h b=%h required 1 3c00 4000", st_cnt - st0, cap_a, cap_b);
    end
    use_fixed = 0;
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int st0 = st_cnt, n = 0;
    send(16'h1234, 0);
    send(16'h0101, 1);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    d = out_data; c = out_count; st0 = st_cnt;
    in_valid = 1; in_data = 16'hAAAA; in_last = 1;
    for (int i = 0; i < 10; i++) begin
      ncmp++;
      if (out_valid !== 1 || out_data !== 16'h1335 || d !== 16'h1335 || out_count !== c || c !== 2 || in_ready !== 0 || st_cnt !== st0) begin
        nerr++;
        $display("FAIL backpressure cyc%0d valid=%b data=%h cnt=%0d rdy=%b pulses=%0d required 1 1335 2 0 0", i, out_valid, out_data, out_count, in_ready, st_cnt - st0);
      end
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    ncmp++;
    if (out_valid !== 0) begin nerr++; $display("FAIL backpressure_release out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    dly_q.push_back(8);
    send(16'h1111, 0);
    send(16'h2222, 1);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    ncmp++;
    if (in_ready !== 0 || add_st !== 0 || out_valid !== 0) begin
      nerr++;
      $display("FAIL reset_mid_cycle rdy=%b st=%b val=%b required 0 0 0", in_ready, add_st, out_valid);
    end
    reset = 0;
    repeat (10) @(negedge clk);
    ncmp++;
    if (add_done !== 1 || add_a !== 0 || add_b !== 0 || out_data !== 0 || out_count !== 0 || out_valid !== 0 || {out_ovf, out_unf, out_err} !== 3'b0 || in_ready !== 1) begin
      nerr++;
      $display("FAIL reset_mid_after done=%b a=%h b=%h d=%h c=%0d val=%b rdy=%b required 1 0 0 0 0 0 1", add_done, add_a, add_b, out_data, out_count, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    run_frame(3, 0, 0, 0, 2, "ovf_second_add");
    run_frame(5, 0, 0, 2, 0, "timeout_discard");
    run_frame(4, 0, 0, 0, 0, "after_timeout");
    run_frame(3, 0, 0, 2, 0, "timeout_on_last");
    test_backpressure();
    test_reset_mid();
    run_frame(3, 0, 0, 0, 0, "after_reset");
    for (int f = 0; f < 20; f++) run_frame(int'($urandom_range(1, 8)), 15, 15, 0, 0, "random");
    run_frame(300, 5, 5, 0, 0, "saturate");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
